// File: rtl/dvp_frame_tx.sv
// OV7725-style DVP transmitter: streams RGB565 frames as VSYNC/HREF-framed bytes,
// sourced from a frame-buffer read port or an internal colour-bar generator.
module dvp_frame_tx #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int ADDR_W      = 17
) (
  input  logic              pclk,
  input  logic              iRST_N,
  input  logic              enable,
  input  logic              pattern_en,
  output logic [ADDR_W-1:0] frame_addr,
  input  logic [15:0]       frame_pixel,
  output logic              vsync,
  output logic              href,
  output logic [7:0]        d,
  output logic              busy,
  output logic              frame_done
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int HW       = $clog2(LINE_LEN);
  localparam int LW       = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);

  localparam logic [HW-1:0]     H_LAST    = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0]     HREF_END  = HW'(2 * H_ACTIVE);
  localparam logic [HW-1:0]     FETCH_END = HW'(2 * H_ACTIVE - 2);
  localparam logic [HW-1:0]     H_ONE     = HW'(1);
  localparam logic [LW-1:0]     L_ONE     = LW'(1);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t            state_r, state_nx_s, after_s;
  logic [HW-1:0]     hcnt_r, hcnt_nx_s;
  logic [LW-1:0]     lcnt_r, lcnt_nx_s;
  logic              pattern_r;
  logic [15:0]       pix_r, pix_src_s;
  logic              href_nx_s, step_s;
  logic [ADDR_W-1:0] addr_nx_s;

  function automatic logic [LW-1:0] last_line(input state_t st);
    case (st)
      ST_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      ST_VBACK:  last_line = LW'(V_BACK - 1);
      ST_ACTIVE: last_line = LW'(V_ACTIVE - 1);
      ST_VFRONT: last_line = LW'(V_FRONT - 1);
      default:   last_line = {LW{1'b0}};
    endcase
  endfunction

  // Last cycle of a frame; with no front porch the frame ends on the last active line.
  function automatic logic frame_last(input state_t st, input logic [LW-1:0] l,
                                      input logic [HW-1:0] h);
    frame_last = 1'b0;
    if (h == H_LAST && l == last_line(st)) begin
      case (st)
        ST_VFRONT: frame_last = 1'b1;
        ST_ACTIVE: frame_last = (V_FRONT == 0);
        default:   frame_last = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [15:0] bar_color(input logic [HW-2:0] col);
    logic [2:0] idx;
    idx = 3'((32'(col) * 32'd8) / H_ACTIVE);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // Successor state once the current state has run all its lines; empty porches are skipped.
  always_comb begin
    after_s = ST_IDLE;
    case (state_r)
      ST_VSYNC:  after_s = (V_BACK != 0) ? ST_VBACK : ST_ACTIVE;
      ST_VBACK:  after_s = ST_ACTIVE;
      ST_ACTIVE: after_s = (V_FRONT != 0) ? ST_VFRONT : (enable ? ST_VSYNC : ST_IDLE);
      ST_VFRONT: after_s = enable ? ST_VSYNC : ST_IDLE;
      default:   after_s = ST_IDLE;
    endcase
  end

  // Next raster position (state, line, column).
  always_comb begin
    state_nx_s = state_r;
    hcnt_nx_s  = hcnt_r;
    lcnt_nx_s  = lcnt_r;
    if (state_r == ST_IDLE) begin
      hcnt_nx_s = {HW{1'b0}};
      lcnt_nx_s = {LW{1'b0}};
      if (enable) begin
        state_nx_s = ST_VSYNC;
      end else begin
        state_nx_s = ST_IDLE;
      end
    end else if (hcnt_r == H_LAST) begin
      hcnt_nx_s = {HW{1'b0}};
      if (lcnt_r == last_line(state_r)) begin
        lcnt_nx_s  = {LW{1'b0}};
        state_nx_s = after_s;
      end else begin
        lcnt_nx_s = lcnt_r + L_ONE;
      end
    end else begin
      hcnt_nx_s = hcnt_r + H_ONE;
    end
  end

  // Outputs are loaded from the next position so vsync/href/d leave the same edge together.
  // Pixel c is addressed in cycles 2c-2..2c-1, its data sampled at the end of 2c-1.
  always_comb begin
    href_nx_s = (state_nx_s == ST_ACTIVE) && (hcnt_nx_s < HREF_END);
    if (pattern_r) begin
      pix_src_s = bar_color(hcnt_nx_s[HW-1:1]);
    end else begin
      pix_src_s = frame_pixel;
    end
    step_s = ((state_r == ST_ACTIVE) && hcnt_r[0] && (hcnt_r < FETCH_END)) ||
             ((hcnt_r == H_LAST) && (state_nx_s == ST_ACTIVE));
    if (step_s && (frame_addr != ADDR_LAST)) begin
      addr_nx_s = frame_addr + A_ONE;
    end else if (state_r == ST_ACTIVE) begin
      addr_nx_s = frame_addr;
    end else begin
      addr_nx_s = {ADDR_W{1'b0}};
    end
  end

  // Raster state, pixel pipeline and registered outputs.
  always_ff @(posedge pclk or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r    <= ST_IDLE;
      hcnt_r     <= {HW{1'b0}};
      lcnt_r     <= {LW{1'b0}};
      pattern_r  <= 1'b0;
      pix_r      <= 16'h0000;
      frame_addr <= {ADDR_W{1'b0}};
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      hcnt_r     <= hcnt_nx_s;
      lcnt_r     <= lcnt_nx_s;
      frame_addr <= addr_nx_s;
      if (state_nx_s == ST_VSYNC && state_r != ST_VSYNC) begin
        pattern_r <= pattern_en;
      end
      if (href_nx_s && !hcnt_nx_s[0]) begin
        pix_r <= pix_src_s;
        d     <= pix_src_s[15:8];
      end else if (href_nx_s) begin
        d <= pix_r[7:0];
      end else begin
        d <= 8'h00;
      end
      vsync      <= (state_nx_s == ST_VSYNC);
      href       <= href_nx_s;
      busy       <= (state_nx_s != ST_IDLE);
      frame_done <= frame_last(state_nx_s, lcnt_nx_s, hcnt_nx_s);
    end
  end

endmodule
